// File: rtl/i2c_codec_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_codec_target
// Brief    : Write-only I2C target for the codec control port. Decodes
//            {DEV_ADDR,W},{reg[6:0],d8},{d[7:0]} frames into write strobes.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_codec_target #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         FILT_LEN = 3
) (
    input  logic       CLOCK31_5,
    input  logic       RESET,
    input  logic       I2C_SCLK,
    input  logic       I2C_SDAT_in,
    output logic       SDAT_oe,
    output logic       wr_valid,
    output logic [6:0] wr_addr,
    output logic [8:0] wr_data,
    output logic       busy,
    output logic [7:0] nack_cnt
);

    localparam logic [2:0] c_filt_max  = 3'(FILT_LEN - 1);
    localparam logic [7:0] c_addr_byte = {DEV_ADDR, 1'b0};

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_BYTE1    = 3'd3;
    localparam logic [2:0] S_ACK1     = 3'd4;
    localparam logic [2:0] S_BYTE2    = 3'd5;
    localparam logic [2:0] S_ACK2     = 3'd6;
    localparam logic [2:0] S_IGNORE   = 3'd7;

    // Bit 0 carries SCL, bit 1 carries SDA through the sync/filter path.
    logic [1:0] w_raw, w_filt, w_rise, w_fall;
    assign w_raw = {I2C_SDAT_in, I2C_SCLK};

    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic       r_s1, r_s2, r_lvl, r_lvl_d;
        logic [2:0] r_cnt;

        always_ff @(posedge CLOCK31_5 or posedge RESET) begin
            if (RESET) begin
                r_s1    <= 1'b1;
                r_s2    <= 1'b1;
                r_lvl   <= 1'b1;
                r_lvl_d <= 1'b1;
                r_cnt   <= 3'd0;
            end else begin
                r_s1    <= w_raw[gi];
                r_s2    <= r_s1;
                r_lvl_d <= r_lvl;
                if (r_s2 == r_lvl) begin
                    r_cnt <= 3'd0;
                end else if (r_cnt == c_filt_max) begin
                    r_lvl <= r_s2;
                    r_cnt <= 3'd0;
                end else begin
                    r_cnt <= r_cnt + 3'd1;
                end
            end
        end

        assign w_filt[gi] = r_lvl;
        assign w_rise[gi] = r_lvl & ~r_lvl_d;
        assign w_fall[gi] = ~r_lvl & r_lvl_d;
    end

    logic w_start, w_stop;
    assign w_start = w_fall[1] & w_filt[0];
    assign w_stop  = w_rise[1] & w_filt[0];

    logic [2:0] r_state, w_state_n;
    logic [2:0] r_bitcnt, w_bitcnt_n;
    logic       r_got8, w_got8_n;
    logic [7:0] r_shift, w_shift_n, w_shift_new;
    logic [6:0] r_reg, w_reg_n;
    logic       r_d8, w_d8_n;
    logic       r_oe, w_oe_n;
    logic       r_busy, w_busy_n;
    logic [7:0] r_nack, w_nack_n, w_nack_inc;
    logic       r_wr_valid, w_wr_valid_n;
    logic [6:0] r_wr_addr, w_wr_addr_n;
    logic [8:0] r_wr_data, w_wr_data_n;

    assign w_shift_new = {r_shift[6:0], w_filt[1]};
    assign w_nack_inc  = (r_nack == 8'hFF) ? r_nack : r_nack + 8'd1;

    always_comb begin
        w_state_n    = r_state;
        w_bitcnt_n   = r_bitcnt;
        w_got8_n     = r_got8;
        w_shift_n    = r_shift;
        w_reg_n      = r_reg;
        w_d8_n       = r_d8;
        w_oe_n       = r_oe;
        w_busy_n     = r_busy;
        w_nack_n     = r_nack;
        w_wr_valid_n = 1'b0;
        w_wr_addr_n  = r_wr_addr;
        w_wr_data_n  = r_wr_data;

        if (w_stop) begin
            w_state_n  = S_IDLE;
            w_busy_n   = 1'b0;
            w_oe_n     = 1'b0;
            w_bitcnt_n = 3'd0;
            w_got8_n   = 1'b0;
        end else if (w_start) begin
            w_state_n  = S_ADDR;
            w_busy_n   = 1'b1;
            w_oe_n     = 1'b0;
            w_bitcnt_n = 3'd0;
            w_got8_n   = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_BYTE1, S_BYTE2, S_IGNORE: begin
                    if (w_scl_rise_sel(w_rise)) begin
                        if (r_got8) begin
                            // Ninth (ACK) clock of a byte we are not answering.
                            w_got8_n   = 1'b0;
                            w_bitcnt_n = 3'd0;
                        end else begin
                            w_shift_n  = w_shift_new;
                            w_bitcnt_n = r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                w_got8_n = 1'b1;
                                if (r_state == S_ADDR && w_shift_new != c_addr_byte) begin
                                    w_state_n = S_IGNORE;
                                    w_nack_n  = w_nack_inc;
                                end else if (r_state == S_IGNORE) begin
                                    w_nack_n  = w_nack_inc;
                                end else if (r_state == S_BYTE1) begin
                                    w_reg_n = w_shift_new[7:1];
                                    w_d8_n  = w_shift_new[0];
                                end
                            end
                        end
                    end else if (w_fall[0] && r_got8 && r_state != S_IGNORE) begin
                        w_oe_n   = 1'b1;
                        w_got8_n = 1'b0;
                        w_state_n = (r_state == S_ADDR)  ? S_ADDR_ACK :
                                    (r_state == S_BYTE1) ? S_ACK1 : S_ACK2;
                    end
                end
                S_ADDR_ACK, S_ACK1, S_ACK2: begin
                    if (w_fall[0]) begin
                        w_oe_n     = 1'b0;
                        w_bitcnt_n = 3'd0;
                        w_state_n  = (r_state == S_ADDR_ACK) ? S_BYTE1 :
                                     (r_state == S_ACK1)     ? S_BYTE2 : S_IGNORE;
                        if (r_state == S_ACK2) begin
                            w_wr_valid_n = 1'b1;
                            w_wr_addr_n  = r_reg;
                            w_wr_data_n  = {r_d8, r_shift};
                        end
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end
    end

    function automatic logic w_scl_rise_sel(input logic [1:0] rise);
        return rise[0];
    endfunction

    always_ff @(posedge CLOCK31_5 or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_bitcnt   <= 3'd0;
            r_got8     <= 1'b0;
            r_shift    <= 8'd0;
            r_reg      <= 7'd0;
            r_d8       <= 1'b0;
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_nack     <= 8'd0;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 7'd0;
            r_wr_data  <= 9'd0;
        end else begin
            r_state    <= w_state_n;
            r_bitcnt   <= w_bitcnt_n;
            r_got8     <= w_got8_n;
            r_shift    <= w_shift_n;
            r_reg      <= w_reg_n;
            r_d8       <= w_d8_n;
            r_oe       <= w_oe_n;
            r_busy     <= w_busy_n;
            r_nack     <= w_nack_n;
            r_wr_valid <= w_wr_valid_n;
            r_wr_addr  <= w_wr_addr_n;
            r_wr_data  <= w_wr_data_n;
        end
    end

    assign SDAT_oe  = r_oe;
    assign wr_valid = r_wr_valid;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign nack_cnt = r_nack;

endmodule
`default_nettype wire
